// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs big-endian 32-bit words into 512-bit blocks and applies the 0x80 marker, zero fill and 64-bit length.
// Latency: a block is valid the cycle after its completing word is accepted. Input stalls (in_ready low) while a block waits for block_ready.
module sha256_padder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic [511:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_first,
  output logic         block_last
);

  typedef enum logic [1:0] {FILL, EMIT, PAD2} state_t;

  state_t         state_q, state_d;
  logic [511:0]   buf_q, buf_d;
  logic [3:0]     idx_q, idx_d;
  logic [63:0]    len_q, len_d;
  logic           first_pend_q, first_pend_d;
  logic           pad2_pend_q, pad2_pend_d;
  logic           pad2_mark_q, pad2_mark_d;
  logic           in_ready_q, in_ready_d;
  logic           valid_q, valid_d;
  logic           first_q, first_d;
  logic           last_q, last_d;

  logic [2:0]     nb;
  logic [31:0]    last_word;
  logic [63:0]    len_fin;
  logic [4:0]     p;
  logic [511:0]   fill_blk;

  assign in_ready    = in_ready_q;
  assign block_out   = buf_q;
  assign block_valid = valid_q;
  assign block_first = first_q;
  assign block_last  = last_q;

  // Final-word shaping: keep the valid bytes and drop the marker right behind them.
  always_comb begin
    nb = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    case (nb)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data[31:16], 16'h8000};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
    len_fin = len_q + {58'd0, nb, 3'd0};
    p = (nb == 3'd4) ? ({1'b0, idx_q} + 5'd1) : {1'b0, idx_q};

    fill_blk = buf_q;
    for (int w = 0; w < 16; w++) begin
      if (5'(w) == {1'b0, idx_q}) begin
        fill_blk[511-32*w -: 32] = last_word;
      end else if (5'(w) > {1'b0, idx_q}) begin
        if ((nb == 3'd4) && (5'(w) == p)) fill_blk[511-32*w -: 32] = 32'h8000_0000;
        else                              fill_blk[511-32*w -: 32] = 32'h0;
      end
    end
    if (p <= 5'd13) fill_blk[63:0] = len_fin;
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    idx_d        = idx_q;
    len_d        = len_q;
    first_pend_d = first_pend_q;
    pad2_pend_d  = pad2_pend_q;
    pad2_mark_d  = pad2_mark_q;
    valid_d      = valid_q;
    first_d      = first_q;
    last_d       = last_q;

    case (state_q)
      FILL: begin
        if (in_valid && in_ready_q) begin
          if (!in_last) begin
            for (int w = 0; w < 16; w++) begin
              if (4'(w) == idx_q) buf_d[511-32*w -: 32] = in_data;
            end
            idx_d = idx_q + 4'd1;
            len_d = len_q + 64'd32;
            if (idx_q == 4'd15) begin
              state_d      = EMIT;
              valid_d      = 1'b1;
              first_d      = first_pend_q;
              last_d       = 1'b0;
              first_pend_d = 1'b0;
              pad2_pend_d  = 1'b0;
            end
          end else begin
            buf_d        = fill_blk;
            len_d        = len_fin;
            state_d      = EMIT;
            valid_d      = 1'b1;
            first_d      = first_pend_q;
            first_pend_d = 1'b0;
            // Length only fits if the marker landed at or before W13.
            if (p <= 5'd13) begin
              last_d      = 1'b1;
              pad2_pend_d = 1'b0;
            end else begin
              last_d      = 1'b0;
              pad2_pend_d = 1'b1;
              pad2_mark_d = (p == 5'd16);
            end
          end
        end
      end
      EMIT: begin
        if (block_ready) begin
          valid_d = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
          if (pad2_pend_q) begin
            state_d = PAD2;
          end else begin
            state_d = FILL;
            idx_d   = 4'd0;
            buf_d   = '0;
            if (last_q) begin
              len_d        = 64'd0;
              first_pend_d = 1'b1;
            end
          end
        end
      end
      PAD2: begin
        buf_d          = '0;
        buf_d[511:480] = pad2_mark_q ? 32'h8000_0000 : 32'h0;
        buf_d[63:0]    = len_q;
        state_d        = EMIT;
        valid_d        = 1'b1;
        first_d        = 1'b0;
        last_d         = 1'b1;
        pad2_pend_d    = 1'b0;
        pad2_mark_d    = 1'b0;
      end
      default: state_d = FILL;
    endcase

    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      buf_q        <= '0;
      idx_q        <= 4'd0;
      len_q        <= 64'd0;
      first_pend_q <= 1'b1;
      pad2_pend_q  <= 1'b0;
      pad2_mark_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      first_pend_q <= first_pend_d;
      pad2_pend_q  <= pad2_pend_d;
      pad2_mark_q  <= pad2_mark_d;
      in_ready_q   <= in_ready_d;
      valid_q      <= valid_d;
      first_q      <= first_d;
      last_q       <= last_d;
    end
  end

endmodule
